pipelined_subtractor: RTL and testbench

PIPELINED_SUBTRACTOR -- requirements
Module: pipelined_subtractor

---
 rtl/pipelined_subtractor_if.sv | 11 +
 rtl/pipelined_subtractor.sv | 83 ++++++++
 tb/tb_pipelined_subtractor.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/pipelined_subtractor_if.sv
// Operand/result bus for pipelined_subtractor. All three words are chunk-skewed.
interface pipelined_subtractor_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic [WIDTH:0]   out;

  modport master (output in1, output in2, input out);
  modport slave  (input in1, input in2, output out);
endinterface

// File: rtl/pipelined_subtractor.sv
// Chunked ripple subtractor on chunk-skewed operands: out = in1 - in2 over WIDTH+1 bits.
// Each CHUNK-bit slice adds in1 + ~in2 plus a carry that was registered one enabled cycle
// earlier from the slice below. Slice i of a word therefore arrives one cycle after slice i-1,
// and the result keeps that skew.
module pipelined_subtractor #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CHUNK = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  pipelined_subtractor_if.slave   bus
);

  localparam int unsigned N = (WIDTH + CHUNK - 1) / CHUNK;
  // When WIDTH is a multiple of CHUNK the sign bit lands in its own 1-bit output chunk,
  // which needs one more carry stage to keep the skew.
  localparam bit TopChunk = (WIDTH % CHUNK) == 0;
  localparam int unsigned NumCarry = TopChunk ? N : N - 1;
  localparam int unsigned CarryW = (NumCarry > 0) ? NumCarry : 1;

  logic [N-1:0]       cin;
  logic [N-1:0]       cout;
  logic [WIDTH-1:0]   sum_bits;
  logic               sign_bit;
  logic [CarryW-1:0]  carry_d, carry_q;
  logic [WIDTH:0]     out_d, out_q;

  for (genvar i = 0; i < N; i++) begin : g_chunk
    localparam int unsigned Lo = i * CHUNK;
    localparam int unsigned Hi = (Lo + CHUNK < WIDTH) ? Lo + CHUNK - 1 : WIDTH - 1;
    localparam int unsigned W  = Hi - Lo + 1;
    localparam int unsigned SW = W + 1;

    logic [W:0] s;

    if (i == 0) begin : g_cin_first
      // Two's-complement subtract: +1 enters at the LSB chunk.
      assign cin[i] = 1'b1;
    end else begin : g_cin_rest
      assign cin[i] = carry_q[i-1];
    end

    assign s = {1'b0, bus.in1[Hi:Lo]} + {1'b0, ~bus.in2[Hi:Lo]} + SW'(cin[i]);
    assign sum_bits[Hi:Lo] = s[W-1:0];
    assign cout[i] = s[W];
  end

  if (TopChunk) begin : g_sign_delayed
    // Borrow comes from the carry already registered, giving one extra cycle of skew.
    assign sign_bit = ~carry_q[N-1];
  end else begin : g_sign_inline
    // Sign travels with the sum bits of the last chunk.
    assign sign_bit = ~cout[N-1];
  end

  // Next carries: each boundary captures the carry-out of the chunk below it.
  always_comb begin
    carry_d = '0;
    for (int i = 0; i < int'(NumCarry); i++) begin
      carry_d[i] = cout[i];
    end
  end

  // Next output word: sum bits of every chunk plus the sign/borrow bit.
  always_comb begin
    out_d = {sign_bit, sum_bits};
  end

  // Pipeline state: async clear, frozen while en is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      carry_q <= '0;
      out_q   <= '0;
    end else if (en) begin
      carry_q <= carry_d;
      out_q   <= out_d;
    end
  end

  assign bus.out = out_q;

endmodule

// File: tb/tb_pipelined_subtractor.sv
// Bench for pipelined_subtractor: WIDTH=8/CHUNK=3 (sign inside last chunk) and
// WIDTH=6/CHUNK=3 (sign in its own top chunk) driven side by side with skewed random words.
module tb_pipelined_subtractor;

  localparam int WA = 8;
  localparam int WB = 6;
  localparam int C  = 3;
  localparam int MA = (WA + 1 + C - 1) / C;  // output chunks, A
  localparam int MB = (WB + 1 + C - 1) / C;  // output chunks, B
  localparam int Depth = 2048;

  logic clk = 1'b0;
  logic rst;
  logic en;

  pipelined_subtractor_if #(.WIDTH(WA)) bus_a ();
  pipelined_subtractor_if #(.WIDTH(WB)) bus_b ();

  pipelined_subtractor #(.WIDTH(WA), .CHUNK(C)) u_dut_a (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .bus (bus_a)
  );

  pipelined_subtractor #(.WIDTH(WB), .CHUNK(C)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .bus (bus_b)
  );

  always #5 clk = ~clk;

  // Logical words indexed by the enabled cycle in which their chunk 0 is on the bus.
  logic [WA-1:0] a1 [Depth];
  logic [WA-1:0] a2 [Depth];
  logic [WB-1:0] b1 [Depth];
  logic [WB-1:0] b2 [Depth];
  // Deskewed DUT results, assembled chunk by chunk.
  logic [WA:0]   obs_a [Depth];
  logic [WB:0]   obs_b [Depth];

  int slot;        // enabled-cycle index of the next enabled edge
  int valid_from;  // first word index started after the latest reset
  int checks;
  int failures;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Put chunk i of word slot-i on the bus.
  task automatic drive_slot();
    logic [WA-1:0] va1, va2;
    logic [WB-1:0] vb1, vb2;
    for (int b = 0; b < WA; b++) begin
      int k;
      k = slot - b / C;
      va1[b] = (k >= 0) ? a1[k][b] : 1'b0;
      va2[b] = (k >= 0) ? a2[k][b] : 1'b0;
    end
    for (int b = 0; b < WB; b++) begin
      int k;
      k = slot - b / C;
      vb1[b] = (k >= 0) ? b1[k][b] : 1'b0;
      vb2[b] = (k >= 0) ? b2[k][b] : 1'b0;
    end
    bus_a.in1 = va1;
    bus_a.in2 = va2;
    bus_b.in1 = vb1;
    bus_b.in2 = vb2;
  endtask

  // One clock edge. Enabled: collect output chunks and compare finished words against
  // plain subtraction. Disabled: noise on inputs, outputs must not move.
  task automatic step(input logic en_v);
    logic [WA:0] prev_a, exp_a;
    logic [WB:0] prev_b, exp_b;
    int k;
    en = en_v;
    if (en_v) begin
      drive_slot();
    end else begin
      bus_a.in1 = WA'($urandom);
      bus_a.in2 = WA'($urandom);
      bus_b.in1 = WB'($urandom);
      bus_b.in2 = WB'($urandom);
    end
    prev_a = bus_a.out;
    prev_b = bus_b.out;
    @(posedge clk);
    #1;
    if (en_v) begin
      // Output chunk j seen after this edge belongs to word slot-j.
      for (int b = 0; b <= WA; b++) begin
        k = slot - b / C;
        if (k >= 0) obs_a[k][b] = bus_a.out[b];
      end
      for (int b = 0; b <= WB; b++) begin
        k = slot - b / C;
        if (k >= 0) obs_b[k][b] = bus_b.out[b];
      end
      k = slot - (MA - 1);
      if (k >= valid_from) begin
        exp_a = {1'b0, a1[k]} - {1'b0, a2[k]};
        check_eq("word_a", 32'(obs_a[k]), 32'(exp_a));
      end
      k = slot - (MB - 1);
      if (k >= valid_from) begin
        exp_b = {1'b0, b1[k]} - {1'b0, b2[k]};
        check_eq("word_b", 32'(obs_b[k]), 32'(exp_b));
      end
      slot++;
    end else begin
      check_eq("frozen_a", 32'(bus_a.out), 32'(prev_a));
      check_eq("frozen_b", 32'(bus_b.out), 32'(prev_b));
    end
  endtask

  initial begin
    int d0;
    checks = 0;
    failures = 0;
    slot = 0;
    valid_from = 0;
    for (int i = 0; i < Depth; i++) begin
      a1[i] = WA'($urandom);
      a2[i] = WA'($urandom);
      b1[i] = WB'($urandom);
      b2[i] = WB'($urandom);
      obs_a[i] = '0;
      obs_b[i] = '0;
    end
    // Directed words at the start of the stream.
    a1[0] = 8'd5;   a2[0] = 8'd3;
    a1[1] = 8'd3;   a2[1] = 8'd5;
    a1[2] = 8'd0;   a2[2] = 8'd255;
    a1[3] = 8'd255; a2[3] = 8'd0;
    a1[4] = 8'd0;   a2[4] = 8'd1;
    b1[0] = 6'd0;   b2[0] = 6'd1;

    rst = 1'b0;
    en = 1'b0;
    drive_slot();
    #1;
    check_eq("reset_a", 32'(bus_a.out), 32'h0);
    check_eq("reset_b", 32'(bus_b.out), 32'h0);
    #1;
    rst = 1'b1;

    for (int i = 0; i < 8; i++) step(1'b1);
    check_eq("dir_5m3", 32'(obs_a[0]), 32'h002);
    check_eq("dir_3m5", 32'(obs_a[1]), 32'h1FE);
    check_eq("dir_0m255", 32'(obs_a[2]), 32'h101);
    check_eq("dir_255m0", 32'(obs_a[3]), 32'h0FF);
    check_eq("dir_0m1_a", 32'(obs_a[4]), 32'h1FF);
    check_eq("dir_0m1_b", 32'(obs_b[0]), 32'h7F);

    // Random stream with a 4-cycle freeze in the middle.
    for (int i = 0; i < 300; i++) step(1'b1);
    for (int i = 0; i < 4; i++) step(1'b0);
    for (int i = 0; i < 300; i++) step(1'b1);

    // Asynchronous reset between edges, mid-stream.
    #2;
    rst = 1'b0;
    #1;
    check_eq("midrst_a", 32'(bus_a.out), 32'h0);
    check_eq("midrst_b", 32'(bus_b.out), 32'h0);
    #2;
    rst = 1'b1;
    valid_from = slot;
    d0 = slot;
    a1[d0] = 8'd0; a2[d0] = 8'd1;
    b1[d0] = 6'd0; b2[d0] = 6'd1;

    for (int i = 0; i < 420; i++) step(1'b1);
    check_eq("post_rst_a", 32'(obs_a[d0]), 32'h1FF);
    check_eq("post_rst_b", 32'(obs_b[d0]), 32'h7F);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
